vsfx_opq: RTL
=============

# vsfx_opq

Operand issue queue for the vector simple fixed-point (vsfx) byte shift/rotate units. It accepts issued byte-shift operations over a valid/ready handshake and buffers them in order in a DEPTH-entry FIFO. It presents one operation at a time from a registered output stage, with per-byte shift counts already extracted from vrb. It sits directly upstream of the combinational vsfx byte-shift datapath, which consumes `out_vra` and `out_sh`.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥ 2.
- `TAGW`, 5: width of the destination/ROB tag carried with each op.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: issue request.
- `in_ready` output 1: queue can accept.
- `in_op` input 4: opcode. 0 = vslb, 1 = vsrb, 2 = vsrab, 3 = vrlb; 4–15 are illegal.
- `in_vra` input 32: source operand A, four bytes.
- `in_vrb` input 32: shift operand B.
- `in_tag` input TAGW: result tag.
- `out_valid` output 1: output register holds an op.
- `out_ready` input 1: execution stage consumes.
- `out_op` output 4: registered opcode.
- `out_vra` output 32: registered vra.
- `out_vrb` output 32: registered vrb.
- `out_sh` output 12: per-byte shift counts `{vrb[26:24], vrb[18:16], vrb[10:8], vrb[2:0]}`. Byte 3's count is in bits [11:9].
- `out_tag` output TAGW: registered tag.
- `out_illegal` output 1: registered op had opcode > 3.
- `occ` output $clog2(DEPTH+2): FIFO entries plus `out_valid`.

## Operation
- Storage consists of a circular FIFO with separate read and write pointers of width $clog2(DEPTH), wrapping modulo DEPTH, plus an entry count. It is followed by one output register (OR).
- An input handshake occurs when `in_valid & in_ready`.
  - `in_ready = !flush & (fifo_count < DEPTH)`.
  - `in_ready` does not depend on `in_valid` or `out_ready`.
- An output handshake occurs when `out_valid & out_ready`.
  - The OR reloads when it is empty or being drained.
  - It reloads from the FIFO head if the FIFO is non-empty.
  - Otherwise `out_valid` deasserts.
- `out_sh` and `out_illegal` are computed from the entry as it is written into the OR. They are registered, with no combinational path from input to output.
- Illegal opcodes are accepted and forwarded unchanged with `out_illegal = 1`. The queue never drops them.
- Strict FIFO order: ops leave in the same order they were accepted.
- Simultaneous push and pop on a full FIFO:
  - The pop frees a slot only on the next cycle.
  - `in_ready` stays 0 in that cycle. There is no same-cycle pass-through when full.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both pointers advance.
- `flush`, when high at an edge:
  - Empties the FIFO and the OR, and resets both pointers to 0.
  - Any concurrent push or pop is discarded.
  - `in_ready` is 0 while `flush` is high.

## Timing
- Reset is asynchronous on `rst_n` low. All outputs go to 0: `in_ready`, `out_valid`, `out_op`, `out_vra`, `out_vrb`, `out_sh`, `out_tag`, `out_illegal`, `occ`. Pointers and count are also cleared.
- Deasserting reset takes effect at the next rising edge. `in_ready` rises after release because the FIFO is empty.
- Reset asserted mid-operation discards all contents immediately. No partial state survives.
- Latency, macro off: an op accepted at edge N enters the FIFO. If the OR is free, the op loads into the OR at edge N+1 and `out_valid` is seen after N+1.
- Latency, macro on: see Configuration.
- Throughput: one op per cycle sustained when `out_ready` is held high.
- `occ` updates at the same edge as the handshake that changes it.

## Configuration
- `VSFX_OPQ_BYPASS_EN` defined:
  - Condition: the FIFO is empty, the OR is empty or draining this cycle, and an input handshake occurs.
  - Effect: the op loads directly into the OR at the same edge, giving latency 1. The FIFO is not written.
  - Ordering is still guaranteed, because bypass is only taken when the FIFO is empty.
- `VSFX_OPQ_BYPASS_EN` undefined: every op passes through the FIFO (latency 2). The maximum number of held ops is DEPTH+1 in both builds.

## Test plan
- Single op, empty queue, `out_ready` = 1:
  - Stimulus: push `op` = 0, `vra` = 32'h8040_2010, `vrb` = 32'h0301_0207, tag = 5.
  - Required: `out_sh` = 12'b011_001_010_111 and `out_tag` = 5, with `out_valid` after 2 edges (1 with bypass).
  - Required: `out_valid` is 1 for exactly one cycle.
- Fill with `out_ready` = 0 and DEPTH = 4:
  - Stimulus: push 6 ops with tags 1..6.
  - Required: tags 1..5 are accepted (4 in FIFO + 1 in OR) and `in_ready` = 0 after that.
  - Required: tag 6 stalls and `occ` = 5.
  - Required: after raising `out_ready`, tags 1..6 emerge in order.
- Wrap-around:
  - Stimulus: stream 20 ops with random `out_ready` stalls.
  - Required: output tag sequence equals input sequence and no op is lost or duplicated.
- Full with simultaneous pop:
  - Stimulus: with the FIFO full, hold `in_valid` = 1 and raise `out_ready` for 1 cycle.
  - Required: `in_ready` = 0 in that cycle and 1 the next, and `occ` goes 5 → 4 → 5.
- Illegal opcode:
  - Stimulus: push `op` = 4'hA.
  - Required: the op is forwarded with `out_illegal` = 1 and all other fields intact.
- Flush and async reset:
  - Stimulus: with 3 ops queued, pulse `flush` while `in_valid` = 1.
  - Required: `out_valid` = 0 and `occ` = 0 next edge, and the concurrent input is not accepted.
  - Stimulus: with ops queued, drop `rst_n` between edges.
  - Required: all outputs are 0 immediately.

Source files
------------

// File: rtl/vsfx_opq.sv
// Operand issue queue for the vsfx byte shift/rotate units: DEPTH-entry FIFO plus one registered output stage.
// Optional same-edge bypass into the output register when `VSFX_OPQ_BYPASS_EN is defined.
module vsfx_opq #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [31:0]                in_vra,
    input  logic [31:0]                in_vrb,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_op,
    output logic [31:0]                out_vra,
    output logic [31:0]                out_vrb,
    output logic [11:0]                out_sh,
    output logic [TAGW-1:0]            out_tag,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+2)-1:0] occ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + 2);

    typedef struct packed {
        logic [3:0]      op;
        logic [31:0]     vra;
        logic [31:0]     vrb;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        or_src;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          live;
    logic          push;
    logic          or_load;
    logic          byp;
    logic          fifo_wr;
    logic          fifo_pop;
    logic          or_fill;

    assign in_entry = '{op: in_op, vra: in_vra, vrb: in_vrb, tag: in_tag};

    // live holds in_ready low from reset until the first edge after release.
    assign in_ready = live & !flush & (count < CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign or_load  = !out_valid | out_ready;
    assign fifo_pop = or_load & (count != '0);

`ifdef VSFX_OPQ_BYPASS_EN
    assign byp = push & (count == '0) & or_load;
`else
    assign byp = 1'b0;
`endif

    assign fifo_wr = push & !byp;
    assign or_fill = fifo_pop | byp;
    assign or_src  = byp ? in_entry : mem[rd_ptr];
    assign occ     = OW'(count) + OW'(out_valid);

    // NOTE: payload storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_vra     <= '0;
            out_vrb     <= '0;
            out_sh      <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                out_valid <= 1'b0;
            end else begin
                if (fifo_wr) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (fifo_wr && !fifo_pop) begin
                    count <= count + CW'(1);
                end else if (!fifo_wr && fifo_pop) begin
                    count <= count - CW'(1);
                end
                if (or_load) begin
                    out_valid <= or_fill;
                    if (or_fill) begin
                        out_op      <= or_src.op;
                        out_vra     <= or_src.vra;
                        out_vrb     <= or_src.vrb;
                        out_sh      <= {or_src.vrb[26:24], or_src.vrb[18:16],
                                        or_src.vrb[10:8],  or_src.vrb[2:0]};
                        out_tag     <= or_src.tag;
                        out_illegal <= |or_src.op[3:2];
                    end
                end
            end
        end
    end

endmodule
